// File: rtl/hw_mem_initiate_n.sv
// hw_mem_initiate_n: issues one bundle of up to NPORT reads/writes to memory and returns gathered read data
//   system1000/system1000_rstn  clock, async active-low reset
//   req_*                       request bundle in (counts, pointers, write values), valid/ready
//   mem_rd_* / mem_wr_*         registered memory port strobes, addresses, data; mem_rd_data returns RD_LAT later
//   rsp_*                       response bundle out (clamped read count, gathered data), valid/ready
//   Enable bit i is slot i; packed address/data vectors carry slot 0 in the MSBs.
module hw_mem_initiate_n #(
  parameter int ADDR_W   = 30,
  parameter int DATA_W   = 63,
  parameter int NPORT    = 2,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0,
  parameter int CNT_W    = $clog2(NPORT + 1)
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [CNT_W-1:0]        rd_cnt,
  input  logic [NPORT*ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]        wr_cnt,
  input  logic [NPORT*ADDR_W-1:0] wr_addr,
  input  logic [NPORT*DATA_W-1:0] wr_data,
  output logic [NPORT-1:0]        mem_rd_en,
  output logic [NPORT*ADDR_W-1:0] mem_rd_addr,
  input  logic [NPORT*DATA_W-1:0] mem_rd_data,
  output logic [NPORT-1:0]        mem_wr_en,
  output logic [NPORT*ADDR_W-1:0] mem_wr_addr,
  output logic [NPORT*DATA_W-1:0] mem_wr_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [CNT_W-1:0]        rsp_cnt,
  output logic [NPORT*DATA_W-1:0] rsp_data
);
  typedef enum logic [2:0] {IDLE, WR, RD, WAIT, RESP} state_t;
  state_t state;
  logic [CNT_W-1:0] rd_n, wr_n, rd_cnt_q;
  logic [NPORT-1:0] rd_m, wr_m, rd_m_q;
  logic [NPORT*ADDR_W-1:0] rd_addr_m, wr_addr_m, rd_addr_q;
  logic [NPORT*DATA_W-1:0] wr_data_m, rd_data_m;
  logic [1:0] lat;
  // clamp counts, build slot masks and zero the address/data of unused slots
  always_comb begin
    rd_n = rd_cnt > CNT_W'(NPORT) ? CNT_W'(NPORT) : rd_cnt;
    wr_n = wr_cnt > CNT_W'(NPORT) ? CNT_W'(NPORT) : wr_cnt;
    rd_m = '0;
    wr_m = '0;
    rd_addr_m = '0;
    wr_addr_m = '0;
    wr_data_m = '0;
    rd_data_m = '0;
    for (int i = 0; i < NPORT; i++) begin
      rd_m[i] = CNT_W'(i) < rd_n;
      wr_m[i] = CNT_W'(i) < wr_n;
      rd_addr_m[(NPORT-1-i)*ADDR_W +: ADDR_W] = rd_m[i] ? rd_addr[(NPORT-1-i)*ADDR_W +: ADDR_W] : '0;
      wr_addr_m[(NPORT-1-i)*ADDR_W +: ADDR_W] = wr_m[i] ? wr_addr[(NPORT-1-i)*ADDR_W +: ADDR_W] : '0;
      wr_data_m[(NPORT-1-i)*DATA_W +: DATA_W] = wr_m[i] ? wr_data[(NPORT-1-i)*DATA_W +: DATA_W] : '0;
      rd_data_m[(NPORT-1-i)*DATA_W +: DATA_W] = rd_m_q[i] ? mem_rd_data[(NPORT-1-i)*DATA_W +: DATA_W] : '0;
    end
  end
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      mem_rd_en   <= '0;
      mem_rd_addr <= '0;
      mem_wr_en   <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      rsp_valid   <= 1'b0;
      rsp_cnt     <= '0;
      rsp_data    <= '0;
      rd_cnt_q    <= '0;
      rd_m_q      <= '0;
      rd_addr_q   <= '0;
      lat         <= '0;
    end else begin
      // strobes default low so each one lasts exactly one cycle
      mem_rd_en   <= '0;
      mem_rd_addr <= '0;
      mem_wr_en   <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      case (state)
        IDLE: if (req_valid) begin
          req_ready   <= 1'b0;
          rd_cnt_q    <= rd_n;
          rd_m_q      <= rd_m;
          rd_addr_q   <= rd_addr_m;
          mem_wr_en   <= wr_m;
          mem_wr_addr <= wr_addr_m;
          mem_wr_data <= wr_data_m;
          if (WR_FIRST != 0) state <= WR;
          else begin
            state       <= RD;
            mem_rd_en   <= rd_m;
            mem_rd_addr <= rd_addr_m;
          end
        end
        WR: begin
          state       <= RD;
          mem_rd_en   <= rd_m_q;
          mem_rd_addr <= rd_addr_q;
        end
        RD: begin
          lat <= 2'(RD_LAT - 1);
          if (rd_cnt_q == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_cnt   <= '0;
            rsp_data  <= '0;
          end else state <= WAIT;
        end
        WAIT: if (lat == '0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_cnt   <= rd_cnt_q;
          rsp_data  <= rd_data_m;
        end else lat <= lat - 2'd1;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_cnt   <= '0;
          rsp_data  <= '0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hw_mem_initiate_n.sv
// tb_hw_mem_initiate_n: checks two instances (same-cycle / write-first) against a transaction-level model
module tb_hw_mem_initiate_n;
  localparam int AW = 30, DW = 63, NP = 2, CW = 2;
  typedef struct {
    int k; int rc; int wc;
    logic [NP*AW-1:0] ra; logic [NP*AW-1:0] wa; logic [NP*DW-1:0] wd;
    int hold; bit keep;
    logic [NP-1:0] xrd; logic [NP-1:0] xwr; int xcnt; int xlat;
  } vec_t;
  logic clk;
  logic tb_init;
  logic rstn [2];
  logic req_valid [2], req_ready [2], rsp_valid [2], rsp_ready [2];
  logic [CW-1:0] rd_cnt [2], wr_cnt [2], rsp_cnt [2];
  logic [NP*AW-1:0] rd_addr [2], wr_addr [2], mem_rd_addr [2], mem_wr_addr [2];
  logic [NP*DW-1:0] wr_data [2], mem_rd_data [2], mem_wr_data [2], rsp_data [2];
  logic [NP-1:0] mem_rd_en [2], mem_wr_en [2];
  logic [NP*DW-1:0] pipe [2][4];
  logic [DW-1:0] mem [2][16];
  logic [DW-1:0] ref_mem [2][16];
  int errors = 0, checks = 0;
  vec_t tbl [8];
  vec_t cur, nxt;

  hw_mem_initiate_n #(.ADDR_W(AW), .DATA_W(DW), .NPORT(NP), .RD_LAT(1), .WR_FIRST(0)) dut0 (
    .system1000(clk), .system1000_rstn(rstn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .rd_cnt(rd_cnt[0]), .rd_addr(rd_addr[0]), .wr_cnt(wr_cnt[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_rd_addr(mem_rd_addr[0]), .mem_rd_data(mem_rd_data[0]),
    .mem_wr_en(mem_wr_en[0]), .mem_wr_addr(mem_wr_addr[0]), .mem_wr_data(mem_wr_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_cnt(rsp_cnt[0]), .rsp_data(rsp_data[0]));
  hw_mem_initiate_n #(.ADDR_W(AW), .DATA_W(DW), .NPORT(NP), .RD_LAT(3), .WR_FIRST(1)) dut1 (
    .system1000(clk), .system1000_rstn(rstn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .rd_cnt(rd_cnt[1]), .rd_addr(rd_addr[1]), .wr_cnt(wr_cnt[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_rd_addr(mem_rd_addr[1]), .mem_rd_data(mem_rd_data[1]),
    .mem_wr_en(mem_wr_en[1]), .mem_wr_addr(mem_wr_addr[1]), .mem_wr_data(mem_wr_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_cnt(rsp_cnt[1]), .rsp_data(rsp_data[1]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] fval(input int a);
    return DW'(64'(a + 1) * 64'h0123_4567_89AB_CDEF);
  endfunction

  // memory: read-before-write per edge, junk on unstrobed slots, read data appears RD_LAT cycles later
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int j = 3; j > 0; j--) pipe[k][j] <= pipe[k][j-1];
      for (int i = 0; i < NP; i++)
        pipe[k][0][(NP-1-i)*DW +: DW] <= mem_rd_en[k][i] ? mem[k][mem_rd_addr[k][(NP-1-i)*AW +: 4]] : DW'({$urandom, $urandom});
      for (int a = 0; a < 16; a++) if (tb_init) mem[k][a] <= fval(a);
      for (int i = 0; i < NP; i++)
        if (!tb_init && mem_wr_en[k][i]) mem[k][mem_wr_addr[k][(NP-1-i)*AW +: 4]] <= mem_wr_data[k][(NP-1-i)*DW +: DW];
    end
  end
  assign mem_rd_data[0] = pipe[0][0];
  assign mem_rd_data[1] = pipe[1][2];

  function automatic int clamp(input int n);
    return n > NP ? NP : n;
  endfunction
  function automatic int lat_of(input int k);
    return k == 1 ? 3 : 1;
  endfunction
  function automatic int wf_of(input int k);
    return k == 1 ? 1 : 0;
  endfunction

  function automatic vec_t mk(input int k, rc, wc, ra0, ra1, wa0, wa1, input logic [DW-1:0] wd0, wd1,
                              input int hold, input bit keep, input logic [NP-1:0] xrd, xwr, input int xcnt, xlat);
    vec_t v;
    v.k = k; v.rc = rc; v.wc = wc;
    v.ra = {AW'(ra0), AW'(ra1)}; v.wa = {AW'(wa0), AW'(wa1)}; v.wd = {wd0, wd1};
    v.hold = hold; v.keep = keep; v.xrd = xrd; v.xwr = xwr; v.xcnt = xcnt; v.xlat = xlat;
    return v;
  endfunction

  // expectations straight from the rules: clamped counts, low-slot masks, fixed latency formula
  function automatic vec_t fin(input vec_t v);
    int rcl, wcl;
    rcl = clamp(v.rc); wcl = clamp(v.wc);
    v.xrd = NP'((1 << rcl) - 1);
    v.xwr = NP'((1 << wcl) - 1);
    v.xcnt = rcl;
    v.xlat = rcl > 0 ? 2 + lat_of(v.k) + wf_of(v.k) : 2 + wf_of(v.k);
    return v;
  endfunction

  function automatic vec_t gen();
    vec_t v;
    int a;
    v.k = $urandom_range(0, 1); v.rc = $urandom_range(0, 3); v.wc = $urandom_range(0, 3);
    v.ra = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
    a = $urandom_range(0, 15);
    v.wa = {AW'(a), AW'(a ^ $urandom_range(1, 15))};
    v.wd = {DW'({$urandom, $urandom}), DW'({$urandom, $urandom})};
    v.hold = $urandom_range(0, 3); v.keep = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  function automatic logic [NP*AW-1:0] msk_a(input logic [NP*AW-1:0] a, input int n);
    logic [NP*AW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[(NP-1-i)*AW +: AW] = a[(NP-1-i)*AW +: AW];
    return r;
  endfunction
  function automatic logic [NP*DW-1:0] msk_d(input logic [NP*DW-1:0] d, input int n);
    logic [NP*DW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[(NP-1-i)*DW +: DW] = d[(NP-1-i)*DW +: DW];
    return r;
  endfunction

  // read data seen by the memory: pre-bundle contents, or this bundle's write when writes go first
  function automatic logic [NP*DW-1:0] model_data(input vec_t v);
    logic [NP*DW-1:0] d;
    logic [DW-1:0] val;
    int a;
    d = '0;
    for (int i = 0; i < clamp(v.rc); i++) begin
      a = int'(v.ra[(NP-1-i)*AW +: AW]);
      val = ref_mem[v.k][a];
      if (wf_of(v.k) == 1)
        for (int j = 0; j < clamp(v.wc); j++)
          if (int'(v.wa[(NP-1-j)*AW +: AW]) == a) val = v.wd[(NP-1-j)*DW +: DW];
      d[(NP-1-i)*DW +: DW] = val;
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input int k, input string tag);
    chk($sformatf("k%0d %s req_ready", k, tag), req_ready[k], 1);
    chk($sformatf("k%0d %s rsp_valid", k, tag), rsp_valid[k], 0);
    chk($sformatf("k%0d %s rd_en", k, tag), mem_rd_en[k], 0);
    chk($sformatf("k%0d %s wr_en", k, tag), mem_wr_en[k], 0);
    chk($sformatf("k%0d %s rd_addr", k, tag), mem_rd_addr[k], 0);
    chk($sformatf("k%0d %s wr_addr", k, tag), mem_wr_addr[k], 0);
    chk($sformatf("k%0d %s wr_data", k, tag), mem_wr_data[k], 0);
    chk($sformatf("k%0d %s rsp_cnt", k, tag), rsp_cnt[k], 0);
    chk($sformatf("k%0d %s rsp_data", k, tag), rsp_data[k], 0);
  endtask

  task automatic drive(input vec_t v);
    rd_cnt[v.k] = CW'(v.rc); wr_cnt[v.k] = CW'(v.wc);
    rd_addr[v.k] = v.ra; wr_addr[v.k] = v.wa; wr_data[v.k] = v.wd;
    req_valid[v.k] = 1;
  endtask

  // one transaction, starting at a negedge with the block idle; keep=1 holds the next request on the bus
  task automatic txn(input vec_t v, input vec_t nx);
    int k, wf, rcl, wcl, last;
    logic [NP*DW-1:0] xd;
    bit rv;
    k = v.k; wf = wf_of(k); rcl = clamp(v.rc); wcl = clamp(v.wc);
    last = v.xlat + v.hold + 1;
    xd = model_data(v);
    chk($sformatf("k%0d start req_ready", k), req_ready[k], 1);
    drive(v);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (v.keep) drive(nx);
        else req_valid[k] = 0;
      end
      rv = (c >= v.xlat) && (c < last);
      chk($sformatf("k%0d c%0d wr_en", k, c), mem_wr_en[k], c == 1 ? v.xwr : 2'b00);
      chk($sformatf("k%0d c%0d wr_addr", k, c), mem_wr_addr[k], c == 1 ? msk_a(v.wa, wcl) : '0);
      chk($sformatf("k%0d c%0d wr_data", k, c), mem_wr_data[k], c == 1 ? msk_d(v.wd, wcl) : '0);
      chk($sformatf("k%0d c%0d rd_en", k, c), mem_rd_en[k], c == 1 + wf ? v.xrd : 2'b00);
      chk($sformatf("k%0d c%0d rd_addr", k, c), mem_rd_addr[k], c == 1 + wf ? msk_a(v.ra, rcl) : '0);
      chk($sformatf("k%0d c%0d rsp_valid", k, c), rsp_valid[k], rv);
      chk($sformatf("k%0d c%0d req_ready", k, c), req_ready[k], c == last);
      if (rv) begin
        chk($sformatf("k%0d c%0d rsp_cnt", k, c), rsp_cnt[k], v.xcnt);
        chk($sformatf("k%0d c%0d rsp_data", k, c), rsp_data[k], xd);
      end
      rsp_ready[k] = (c == last - 1);
    end
    for (int j = 0; j < wcl; j++) ref_mem[k][int'(v.wa[(NP-1-j)*AW +: AW])] = v.wd[(NP-1-j)*DW +: DW];
  endtask

  // reset pulled mid-transaction: outputs clear at once, nothing surfaces afterwards
  task automatic rst_mid(input vec_t v, input int at);
    int k;
    k = v.k;
    drive(v);
    for (int c = 1; c <= at; c++) begin
      @(negedge clk);
      if (c == 1) req_valid[k] = 0;
    end
    chk($sformatf("k%0d pre_rst rd_en", k), mem_rd_en[k], at == 1 + wf_of(k) ? v.xrd : 2'b00);
    rstn[k] = 0;
    #1;
    chk_idle(k, "mid_rst");
    @(negedge clk);
    chk_idle(k, "rst_held");
    rstn[k] = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("k%0d post_rst%0d rsp_valid", k, c), rsp_valid[k], 0);
      chk($sformatf("k%0d post_rst%0d req_ready", k, c), req_ready[k], 1);
      chk($sformatf("k%0d post_rst%0d rd_en", k, c), mem_rd_en[k], 0);
    end
  endtask

  initial begin
    logic [DW-1:0] x, y, z;
    x = 63'h1111_2222_3333_4444; y = 63'h5555_6666_7777_0888; z = 63'h0ABC_DEF0_1234_5678;
    tb_init = 1;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 0; req_valid[k] = 0; rsp_ready[k] = 0;
      rd_cnt[k] = '0; wr_cnt[k] = '0; rd_addr[k] = '0; wr_addr[k] = '0; wr_data[k] = '0;
      for (int a = 0; a < 16; a++) ref_mem[k][a] = fval(a);
    end
    tbl[0] = mk(0, 2, 0, 5, 9, 0, 0, '0, '0, 0, 0, 2'b11, 2'b00, 2, 3);
    tbl[1] = mk(0, 1, 2, 3, 7, 3, 4, x, y, 0, 0, 2'b01, 2'b11, 1, 3);
    tbl[2] = mk(1, 1, 2, 3, 7, 3, 4, x, y, 0, 0, 2'b01, 2'b11, 1, 6);
    tbl[3] = mk(0, 0, 1, 2, 6, 6, 0, z, '0, 0, 0, 2'b00, 2'b01, 0, 2);
    tbl[4] = mk(1, 0, 1, 2, 6, 6, 0, z, '0, 0, 0, 2'b00, 2'b01, 0, 3);
    tbl[5] = mk(0, 3, 3, 1, 2, 10, 11, y, z, 0, 0, 2'b11, 2'b11, 2, 3);
    tbl[6] = mk(0, 2, 1, 6, 3, 8, 0, x, '0, 5, 1, 2'b11, 2'b01, 2, 3);
    tbl[7] = mk(0, 1, 0, 4, 9, 0, 0, '0, '0, 0, 0, 2'b01, 2'b00, 1, 3);
    repeat (3) @(negedge clk);
    tb_init = 0;
    chk_idle(0, "reset");
    chk_idle(1, "reset");
    rstn[0] = 1; rstn[1] = 1;
    @(negedge clk);
    chk_idle(0, "released");
    chk_idle(1, "released");
    for (int i = 0; i < 8; i++) txn(tbl[i], tbl[(i + 1) % 8]);
    rst_mid(fin(mk(0, 2, 0, 1, 2, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0)), 1);
    rst_mid(fin(mk(1, 2, 0, 1, 2, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0)), 3);
    txn(fin(mk(1, 2, 1, 12, 13, 13, 0, z, '0, 1, 0, 0, 0, 0, 0)), tbl[0]);
    cur = fin(gen());
    for (int n = 0; n < 150; n++) begin
      nxt = gen();
      if (cur.keep) nxt.k = cur.k;
      nxt = fin(nxt);
      txn(cur, nxt);
      cur = nxt;
    end
    cur.keep = 0;
    txn(cur, cur);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
